branch_sequencer: RTL

- Consumer end of the compare unit's condition output: latches the Yes/No compare result into a flag register and drives the program counter.
- Handles conditional/unconditional branches locally.
- Forwards every non-branch opcode to the execute datapath.
- Fetches from Harvard instruction memory with a req/ready handshake; sits between instruction memory and the ALU/compare datapath.

---
 rtl/hap_pkg.sv | 38 +++
 rtl/branch_rstack.sv | 48 ++++
 rtl/branch_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hap_pkg.sv
// Opcode map, FSM encoding and field helpers shared by the branch sequencer and its stack.
// BRANCH_SEQUENCER_CALL_EN makes CALL/RET control opcodes instead of issued ones.
package hap_pkg;

    localparam int OPC_W = 5;

    // Compare set, executed downstream by the compare unit
    localparam logic [OPC_W-1:0] OP_LT   = 5'b01000;
    localparam logic [OPC_W-1:0] OP_LE   = 5'b01001;
    localparam logic [OPC_W-1:0] OP_GT   = 5'b01010;
    localparam logic [OPC_W-1:0] OP_GE   = 5'b01011;
    localparam logic [OPC_W-1:0] OP_EQ   = 5'b01100;
    localparam logic [OPC_W-1:0] OP_NE   = 5'b01101;

    localparam logic [OPC_W-1:0] OP_JMP  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_BRT  = 5'b10010;
    localparam logic [OPC_W-1:0] OP_BRF  = 5'b10011;
    localparam logic [OPC_W-1:0] OP_HLT  = 5'b10100;
    localparam logic [OPC_W-1:0] OP_CALL = 5'b10101;
    localparam logic [OPC_W-1:0] OP_RET  = 5'b10110;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_HALT   = 2'd2
    } seq_state_e;

    // True for opcodes consumed by the sequencer rather than issued downstream
    function automatic logic is_ctrl_op(input logic [OPC_W-1:0] opc);
        logic ctrl;
        ctrl = (opc == OP_JMP) || (opc == OP_BRT) || (opc == OP_BRF) || (opc == OP_HLT);
`ifdef BRANCH_SEQUENCER_CALL_EN
        ctrl = ctrl || (opc == OP_CALL) || (opc == OP_RET);
`endif
        return ctrl;
    endfunction

endpackage

// File: rtl/branch_rstack.sv
// LIFO of return addresses for CALL/RET; only built when BRANCH_SEQUENCER_CALL_EN is defined.
// Push and pop are ignored when full and empty respectively; the caller treats those as errors.
`ifdef BRANCH_SEQUENCER_CALL_EN
module branch_rstack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] push_data_i,
    output logic [W-1:0] top_data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_dec;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    always_comb begin
        cnt_dec = cnt_q - CNT_W'(1);
        wr_idx  = IDX_W'(cnt_q);
        top_idx = IDX_W'(cnt_dec);
        full_o  = (cnt_q == CNT_W'(DEPTH));
        empty_o = (cnt_q == '0);
        top_data_o = mem_q[top_idx];
    end

    // Entries themselves need no reset: an empty count hides them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (push_i && !full_o) begin
            mem_q[wr_idx] <= push_data_i;
            cnt_q         <= cnt_q + CNT_W'(1);
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_dec;
        end
    end

endmodule
`endif

// File: rtl/branch_sequencer.sv
// Fetch/decode sequencer: owns the PC, resolves branches against the latched compare flag,
// and issues everything else downstream. Optional CALL/RET via BRANCH_SEQUENCER_CALL_EN.
//
// state   | meaning
// FETCH   | imem_req high, waiting for imem_ready to capture the instruction
// DECODE  | ir valid: resolve branch/halt locally or issue (held while stall)
// HALT    | stopped until reset; flag still tracks the compare unit
module branch_sequencer
    import hap_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 16,
    parameter int RSTACK_D = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    input  logic               cmp_valid,
    input  logic               cmp_result,
    input  logic               stall,
    output logic               issue_valid,
    output logic [OPC_W-1:0]   issue_opcode,
    output logic [INSTR_W-1:0] issue_instr,
    output logic               flag,
    output logic               halted
`ifdef BRANCH_SEQUENCER_CALL_EN
    ,
    output logic               stack_err
`endif
);

    if (RSTACK_D < 2) begin : g_depth_chk
        $error("branch_sequencer: RSTACK_D must be at least 2");
    end

    seq_state_e         state_q;
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic               flag_q;
    logic               halted_q;

    logic [OPC_W-1:0]   opc;
    logic [PC_W-1:0]    tgt;
    logic [PC_W-1:0]    pc_inc;
    logic               br_flag;
    logic               br_taken;
    logic               is_ctrl;

    always_comb begin
        opc      = ir_q[INSTR_W-1 -: OPC_W];
        tgt      = ir_q[PC_W-1:0];
        pc_inc   = pc_q + PC_W'(1);
        // A compare landing in the same cycle as the branch wins over the stored flag
        br_flag  = cmp_valid ? cmp_result : flag_q;
        br_taken = (opc == OP_BRT) ? br_flag : ~br_flag;
        is_ctrl  = is_ctrl_op(opc);
    end

`ifdef BRANCH_SEQUENCER_CALL_EN
    logic            stack_err_q;
    logic            rs_push;
    logic            rs_pop;
    logic            rs_full;
    logic            rs_empty;
    logic [PC_W-1:0] rs_top;

    always_comb begin
        rs_push = (state_q == ST_DECODE) && (opc == OP_CALL) && !rs_full;
        rs_pop  = (state_q == ST_DECODE) && (opc == OP_RET)  && !rs_empty;
    end

    branch_rstack #(
        .DEPTH (RSTACK_D),
        .W     (PC_W)
    ) u_rstack (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rs_push),
        .pop_i       (rs_pop),
        .push_data_i (pc_inc),
        .top_data_o  (rs_top),
        .full_o      (rs_full),
        .empty_o     (rs_empty)
    );

    assign stack_err = stack_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            flag_q   <= 1'b0;
            halted_q <= 1'b0;
`ifdef BRANCH_SEQUENCER_CALL_EN
            stack_err_q <= 1'b0;
`endif
        end else begin
            if (cmp_valid) begin
                flag_q <= cmp_result;
            end
            case (state_q)
                ST_FETCH: begin
                    if (imem_ready) begin
                        ir_q    <= instr;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (opc)
                        OP_JMP: begin
                            pc_q    <= tgt;
                            state_q <= ST_FETCH;
                        end
                        OP_BRT, OP_BRF: begin
                            pc_q    <= br_taken ? tgt : pc_inc;
                            state_q <= ST_FETCH;
                        end
                        OP_HLT: begin
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end
`ifdef BRANCH_SEQUENCER_CALL_EN
                        OP_CALL: begin
                            if (rs_full) begin
                                halted_q    <= 1'b1;
                                stack_err_q <= 1'b1;
                                state_q     <= ST_HALT;
                            end else begin
                                pc_q    <= tgt;
                                state_q <= ST_FETCH;
                            end
                        end
                        OP_RET: begin
                            if (rs_empty) begin
                                halted_q    <= 1'b1;
                                stack_err_q <= 1'b1;
                                state_q     <= ST_HALT;
                            end else begin
                                pc_q    <= rs_top;
                                state_q <= ST_FETCH;
                            end
                        end
`endif
                        default: begin
                            if (!stall) begin
                                pc_q    <= pc_inc;
                                state_q <= ST_FETCH;
                            end
                        end
                    endcase
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    always_comb begin
        imem_req     = (state_q == ST_FETCH);
        issue_valid  = (state_q == ST_DECODE) && !is_ctrl && !stall;
        issue_opcode = opc;
        issue_instr  = ir_q;
        pc           = pc_q;
        flag         = flag_q;
        halted       = halted_q;
    end

endmodule
